// File: rtl/modulus_term_csa_accum_pkg.sv
// Shared constants, operand type and tree-depth helper for the moduli-term
// carry-save accumulator.
package modulus_accum_pkg;

  localparam int MODULUS_WIDTH_DEF = 1024;
  localparam int NUM_TERMS_DEF     = 10;
  localparam int GUARD_BITS_DEF    = 4;
  localparam int OUT_WIDTH_DEF     = MODULUS_WIDTH_DEF + GUARD_BITS_DEF;

  typedef logic [OUT_WIDTH_DEF-1:0] opnd_t;

  // Number of 3:2 levels needed to reduce n operands down to a redundant pair.
  function automatic int num_csa_levels(input int n);
    int cnt;
    int lv;
    cnt = n;
    lv  = 0;
    for (int i = 0; i < 32; i++) begin
      if (cnt > 2) begin
        cnt = 2 * (cnt / 3) + (cnt % 3);
        lv  = lv + 1;
      end
    end
    return lv;
  endfunction

endpackage

// File: rtl/modulus_term_csa_accum_csa_3to2.sv
// Width-parameterised combinational 3:2 carry-save compressor; the carry
// vector is already shifted to its binary weight and truncated to W bits.
module csa_3to2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  logic [W-1:0] maj_s;

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign maj_s   = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign carry_o = maj_s << 1;

endmodule

// File: rtl/modulus_term_csa_accum.sv
// Elastic 3-stage carry-save tree: low_part + NUM_TERMS moduli terms -> sum/carry.
// Define MODULUS_CSA_ACCUM_FINAL_CPA_EN to add a 4th stage producing a binary sum.
module modulus_term_csa_accum
  import modulus_accum_pkg::*;
#(
  parameter int MODULUS_WIDTH = MODULUS_WIDTH_DEF,
  parameter int NUM_TERMS     = NUM_TERMS_DEF,
  parameter int GUARD_BITS    = GUARD_BITS_DEF,
  parameter int OUT_WIDTH     = MODULUS_WIDTH + GUARD_BITS
) (
  input  logic                     clk_phase,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MODULUS_WIDTH-1:0] low_part,
  input  logic [MODULUS_WIDTH-1:0] moduli_terms [NUM_TERMS],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_WIDTH-1:0]     out_sum,
  output logic [OUT_WIDTH-1:0]     out_carry
);

  localparam int NUM_OPS = NUM_TERMS + 1;

  if (NUM_TERMS != 10 || num_csa_levels(NUM_OPS) != 5) begin : g_bad_terms
    $error("modulus_term_csa_accum: tree is wired for NUM_TERMS == 10 only");
  end
  if (GUARD_BITS < $clog2(NUM_TERMS + 1)) begin : g_bad_guard
    $error("modulus_term_csa_accum: GUARD_BITS too small for exact sum");
  end

  logic [OUT_WIDTH-1:0] l0_s [NUM_OPS];
  logic [OUT_WIDTH-1:0] l1_s [8];
  logic [OUT_WIDTH-1:0] l2_s [6];
  logic [OUT_WIDTH-1:0] l3_s [4];
  logic [OUT_WIDTH-1:0] l4_s [3];
  logic [OUT_WIDTH-1:0] l5_sum_s, l5_carry_s;

  logic [OUT_WIDTH-1:0] s1_q [6];
  logic [OUT_WIDTH-1:0] s2_q [3];
  logic [OUT_WIDTH-1:0] s3_sum_q, s3_carry_q;
  logic                 s1_v_q, s2_v_q, s3_v_q;
  logic                 s1_v_d, s2_v_d, s3_v_d;
  logic                 s1_rdy_s, s2_rdy_s, s3_rdy_s, tail_rdy_s;

  always_comb begin
    l0_s[0] = OUT_WIDTH'(low_part);
    for (int i = 0; i < NUM_TERMS; i++) begin
      l0_s[i+1] = OUT_WIDTH'(moduli_terms[i]);
    end
  end

  // Levels 1-2 (11 -> 8 -> 6) feed stage S1
  for (genvar k = 0; k < 3; k++) begin : g_l1
    csa_3to2 #(.W(OUT_WIDTH)) u_csa (
      .a_i(l0_s[3*k]), .b_i(l0_s[3*k+1]), .c_i(l0_s[3*k+2]),
      .sum_o(l1_s[2*k]), .carry_o(l1_s[2*k+1])
    );
  end
  assign l1_s[6] = l0_s[9];
  assign l1_s[7] = l0_s[10];

  for (genvar k = 0; k < 2; k++) begin : g_l2
    csa_3to2 #(.W(OUT_WIDTH)) u_csa (
      .a_i(l1_s[3*k]), .b_i(l1_s[3*k+1]), .c_i(l1_s[3*k+2]),
      .sum_o(l2_s[2*k]), .carry_o(l2_s[2*k+1])
    );
  end
  assign l2_s[4] = l1_s[6];
  assign l2_s[5] = l1_s[7];

  // Levels 3-4 (6 -> 4 -> 3) feed stage S2
  for (genvar k = 0; k < 2; k++) begin : g_l3
    csa_3to2 #(.W(OUT_WIDTH)) u_csa (
      .a_i(s1_q[3*k]), .b_i(s1_q[3*k+1]), .c_i(s1_q[3*k+2]),
      .sum_o(l3_s[2*k]), .carry_o(l3_s[2*k+1])
    );
  end

  csa_3to2 #(.W(OUT_WIDTH)) u_l4 (
    .a_i(l3_s[0]), .b_i(l3_s[1]), .c_i(l3_s[2]),
    .sum_o(l4_s[0]), .carry_o(l4_s[1])
  );
  assign l4_s[2] = l3_s[3];

  csa_3to2 #(.W(OUT_WIDTH)) u_l5 (
    .a_i(s2_q[0]), .b_i(s2_q[1]), .c_i(s2_q[2]),
    .sum_o(l5_sum_s), .carry_o(l5_carry_s)
  );

  // Backpressure ripples from the output toward in_ready; in_valid never feeds it.
  always_comb begin
    s3_rdy_s = !s3_v_q || tail_rdy_s;
    s2_rdy_s = !s2_v_q || s3_rdy_s;
    s1_rdy_s = !s1_v_q || s2_rdy_s;
    if (s1_rdy_s) s1_v_d = in_valid; else s1_v_d = s1_v_q;
    if (s2_rdy_s) s2_v_d = s1_v_q;   else s2_v_d = s2_v_q;
    if (s3_rdy_s) s3_v_d = s2_v_q;   else s3_v_d = s3_v_q;
  end

  assign in_ready = s1_rdy_s;

  // Stage valids plus the S3 pair, which is cleared so outputs read 0 after reset
  always_ff @(posedge clk_phase or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s3_v_q     <= 1'b0;
      s3_sum_q   <= '0;
      s3_carry_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s3_v_q <= s3_v_d;
      if (s3_rdy_s && s2_v_q) begin
        s3_sum_q   <= l5_sum_s;
        s3_carry_q <= l5_carry_s;
      end
    end
  end

  // Wide intermediate data is qualified by the valids and needs no reset
  always_ff @(posedge clk_phase) begin
    if (s1_rdy_s && in_valid) s1_q <= l2_s;
    if (s2_rdy_s && s1_v_q)   s2_q <= l4_s;
  end

`ifdef MODULUS_CSA_ACCUM_FINAL_CPA_EN
  logic                 s4_v_q;
  logic [OUT_WIDTH-1:0] s4_sum_q;
  logic                 s4_rdy_s;

  assign s4_rdy_s   = !s4_v_q || out_ready;
  assign tail_rdy_s = s4_rdy_s;

  // Final carry-propagate stage collapses the redundant pair
  always_ff @(posedge clk_phase or negedge rst_n) begin
    if (!rst_n) begin
      s4_v_q   <= 1'b0;
      s4_sum_q <= '0;
    end else begin
      if (s4_rdy_s) s4_v_q <= s3_v_q;
      if (s4_rdy_s && s3_v_q) s4_sum_q <= s3_sum_q + s3_carry_q;
    end
  end

  assign out_valid = s4_v_q;
  assign out_sum   = s4_sum_q;
  assign out_carry = '0;
`else
  assign tail_rdy_s = out_ready;
  assign out_valid  = s3_v_q;
  assign out_sum    = s3_sum_q;
  assign out_carry  = s3_carry_q;
`endif

endmodule

// File: tb/tb_modulus_term_csa_accum.sv
// Randomised self-checking bench for modulus_term_csa_accum against an
// arithmetic reference (exact sum of all operands, in-order queue).
module tb_modulus_term_csa_accum;

  localparam int MW = 1024;
  localparam int NT = 10;
  localparam int GB = 4;
  localparam int OW = MW + GB;
`ifdef MODULUS_CSA_ACCUM_FINAL_CPA_EN
  localparam int LAT = 4;
  localparam int CAP = 4;
`else
  localparam int LAT = 3;
  localparam int CAP = 3;
`endif

  logic          clk_phase = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] low_part;
  logic [MW-1:0] moduli_terms [NT];
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_sum;
  logic [OW-1:0] out_carry;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q [$];

  always #5 clk_phase = ~clk_phase;

  modulus_term_csa_accum dut (
    .clk_phase(clk_phase), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .low_part(low_part), .moduli_terms(moduli_terms),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry)
  );

  function automatic logic [MW-1:0] rand_word();
    logic [MW-1:0] r;
    for (int i = 0; i < MW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [OW-1:0] ref_sum();
    logic [OW-1:0] acc;
    acc = OW'(low_part);
    for (int i = 0; i < NT; i++) acc = acc + OW'(moduli_terms[i]);
    return acc;
  endfunction

  task automatic randomize_ops();
    low_part = rand_word();
    for (int i = 0; i < NT; i++) moduli_terms[i] = rand_word();
  endtask

  // Starts just after a negedge: observes, lets one posedge pass, returns after the next negedge
  task automatic run_cycle(output bit acc, output bit ov, output bit hs,
                           output logic [OW-1:0] res, output logic [OW-1:0] cy);
    logic [OW-1:0] e;
    #1;
    acc = in_valid && in_ready;
    ov  = out_valid;
    hs  = out_valid && out_ready;
    res = out_sum + out_carry;
    cy  = out_carry;
    e   = ref_sum();
    @(posedge clk_phase);
    if (acc) exp_q.push_back(e);
    @(negedge clk_phase);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; low_part = '0;
    for (int i = 0; i < NT; i++) moduli_terms[i] = '0;
    repeat (3) @(negedge clk_phase);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid: got %b want 0", out_valid); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    checks++;
    if (out_sum !== '0 || out_carry !== '0) begin
      errors++; $display("FAIL reset_data: got sum=%h carry=%h want 0", out_sum[63:0], out_carry[63:0]);
    end
    @(negedge clk_phase);
  endtask

  // Shared body for scenarios 1/2/6: single accept then measure latency and value
  task automatic single_shot(input string name, input logic [OW-1:0] want);
    bit acc, ov, hs; logic [OW-1:0] res, cy;
    int n;
    out_ready = 1'b1; in_valid = 1'b1;
    run_cycle(acc, ov, hs, res, cy);
    checks++;
    if (!acc) begin errors++; $display("FAIL %s_accept: in_ready got 0 want 1", name); end
    in_valid = 1'b0;
    n = 0;
    ov = 1'b0;
    while (!ov && n < 20) begin
      n++;
      run_cycle(acc, ov, hs, res, cy);
    end
    checks++;
    if (n != LAT) begin errors++; $display("FAIL %s_latency: got %0d cycles want %0d", name, n, LAT); end
    checks++;
    if (res !== want) begin
      errors++; $display("FAIL %s_value: got %h want %h (low 128 bits)", name, res[127:0], want[127:0]);
    end
`ifdef MODULUS_CSA_ACCUM_FINAL_CPA_EN
    checks++;
    if (cy !== '0) begin errors++; $display("FAIL %s_carry_zero: got %h want 0", name, cy[63:0]); end
`endif
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (2) @(negedge clk_phase);
  endtask

  task automatic test_latency();
    low_part = MW'(5);
    for (int i = 0; i < NT; i++) moduli_terms[i] = MW'(i + 1);
    single_shot("latency60", OW'(60));
  endtask

  task automatic test_all_ones();
    logic [OW-1:0] want;
    want = {OW{1'b1}} >> GB;
    want = want * OW'(11);
    low_part = {MW{1'b1}};
    for (int i = 0; i < NT; i++) moduli_terms[i] = {MW{1'b1}};
    single_shot("all_ones", want);
  endtask

  task automatic test_back_to_back();
    bit acc, ov, hs; logic [OW-1:0] res, cy, e;
    int sent, got, cyc;
    bit started;
    sent = 0; got = 0; cyc = 0; started = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; randomize_ops();
    while (got < 20 && cyc < 60) begin
      if (sent == 20) in_valid = 1'b0;
      run_cycle(acc, ov, hs, res, cy);
      if (sent < 20) begin
        checks++;
        if (!acc) begin errors++; $display("FAIL b2b_in_ready: cycle %0d got 0 want 1", cyc); end
      end
      if (started && got < 20) begin
        checks++;
        if (!hs) begin errors++; $display("FAIL b2b_gap: cycle %0d out_valid got 0 want 1", cyc); end
      end
      if (acc) begin sent++; randomize_ops(); end
      if (hs) begin
        started = 1'b1;
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: result %0d with no pending transaction", got);
        end else begin
          e = exp_q.pop_front();
          if (res !== e) begin
            errors++; $display("FAIL b2b_value: result %0d got %h want %h", got, res[127:0], e[127:0]);
          end
        end
      end
      cyc++;
    end
    checks++;
    if (got != 20) begin errors++; $display("FAIL b2b_count: got %0d results want 20", got); end
  endtask

  task automatic test_stall();
    bit acc, ov, hs; logic [OW-1:0] res, cy, e;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    out_ready = 1'b0; in_valid = 1'b1; randomize_ops();
    while (sent < CAP && cyc < 20) begin
      run_cycle(acc, ov, hs, res, cy);
      if (acc) begin sent++; randomize_ops(); end
      cyc++;
    end
    checks++;
    if (sent != CAP) begin errors++; $display("FAIL stall_fill: accepted %0d want %0d", sent, CAP); end
    for (int k = 0; k < 4; k++) begin
      run_cycle(acc, ov, hs, res, cy);
      checks++;
      if (acc) begin errors++; $display("FAIL stall_in_ready: hold %0d got 1 want 0", k); sent++; randomize_ops(); end
      checks++;
      if (!ov) begin errors++; $display("FAIL stall_out_valid: hold %0d got 0 want 1", k); end
      checks++;
      if (exp_q.size() == 0 || res !== exp_q[0]) begin
        errors++; $display("FAIL stall_hold_data: hold %0d got %h", k, res[127:0]);
      end
    end
    out_ready = 1'b1;
    cyc = 0;
    while ((got < 5 || sent < 5) && cyc < 30) begin
      if (sent == 5) in_valid = 1'b0;
      run_cycle(acc, ov, hs, res, cy);
      if (acc) begin sent++; randomize_ops(); end
      if (hs) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stall_extra: result %0d with no pending transaction", got);
        end else begin
          e = exp_q.pop_front();
          if (res !== e) begin
            errors++; $display("FAIL stall_drain: result %0d got %h want %h", got, res[127:0], e[127:0]);
          end
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 5 || exp_q.size() != 0) begin
      errors++; $display("FAIL stall_count: got %0d results want 5, pending %0d", got, exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    bit acc, ov, hs; logic [OW-1:0] res, cy;
    int sent, cyc;
    sent = 0; cyc = 0;
    out_ready = 1'b0; in_valid = 1'b1; randomize_ops();
    while (sent < 2 && cyc < 10) begin
      run_cycle(acc, ov, hs, res, cy);
      if (acc) begin sent++; randomize_ops(); end
      cyc++;
    end
    in_valid = 1'b0;
    cyc = 0;
    ov = out_valid;
    while (!ov && cyc < 10) begin
      run_cycle(acc, ov, hs, res, cy);
      cyc++;
    end
    checks++;
    if (!out_valid) begin errors++; $display("FAIL midrst_setup: out_valid got 0 want 1"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_async: out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: in_ready got %b want 1", in_ready); end
    exp_q.delete();
    repeat (2) @(negedge clk_phase);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      run_cycle(acc, ov, hs, res, cy);
      checks++;
      if (ov) begin errors++; $display("FAIL midrst_stale: cycle %0d out_valid got 1 want 0", k); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_all_ones();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/modulus_term_csa_accum.md
Name: modulus_term_csa_accum

Overview:
- Downstream consumer of the moduli-term LUT chunk.
- Each transaction takes the NUM_TERMS reduction terms plus the low part of the squared product and compresses them in a pipelined 3:2 carry-save tree.
- Output is a redundant sum/carry pair for the next squaring iteration.
- Uses an elastic valid/ready pipeline, so upstream LUT lookups can stall without losing data.

Parameters:
- MODULUS_WIDTH, 1024: width of each operand.
- NUM_TERMS, 10: number of moduli terms per transaction. The tree is structured for 10; other values are rejected at elaboration.
- GUARD_BITS, 4: extra MSBs. ceil(log2(NUM_TERMS+1)) is the minimum.
- OUT_WIDTH, MODULUS_WIDTH+GUARD_BITS: width of the result vectors (derived).

Ports:
- clk_phase  in  1  clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream operands valid.
- in_ready  out  1  block accepts operands this cycle.
- low_part  in  MODULUS_WIDTH  low half of the square product.
- moduli_terms  in  MODULUS_WIDTH x NUM_TERMS  unpacked array of LUT reduction terms.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  OUT_WIDTH  redundant sum vector.
- out_carry  out  OUT_WIDTH  redundant carry vector, already left-aligned (weight applied).

Behaviour:
- Operand handling:
  - Inputs are zero-extended to OUT_WIDTH.
  - The required invariant is (out_sum + out_carry) mod 2^OUT_WIDTH = low_part + sum of moduli_terms.
  - The exact sum is < 2^OUT_WIDTH, so dropping the CSA carry-out at bit OUT_WIDTH is lossless.
- Tree structure: 11 operands -> 8 -> 6 -> 4 -> 3 -> 2 (five CSA levels), split into three register stages:
  - S1 = levels 1-2 (11 -> 6).
  - S2 = levels 3-4 (6 -> 3).
  - S3 = level 5 (3 -> 2), which drives out_sum/out_carry directly from registers.
- Latency: 3 cycles from an accepted input (in_valid && in_ready) to out_valid when out_ready is held high.
- Throughput: 1 transaction per cycle.
- Stage control:
  - Each stage has a valid bit. Stage k loads when its upstream is valid and (stage k is empty or stage k is advancing).
  - S3 advances when out_ready is high.
  - in_ready = !S1_valid || S1_advancing. This is combinational from out_ready through the stage valids, with no combinational path from in_valid.
- Stalls: with out_ready low, data holds in every stage and in_ready drops once S1 is occupied and S2/S3 are full. Up to 3 transactions are buffered. No data is lost or duplicated.
- out_valid && !out_ready: out_sum/out_carry must stay stable until the handshake completes.
- Simultaneous events: accept and drain in the same cycle are allowed in every stage (full throughput while out_ready is high).
- Reset (asynchronous, any time including mid-stream):
  - All stage valids clear, so out_valid = 0 and in_ready = 1 after deassertion.
  - Data registers need no reset; out_sum/out_carry read 0 after reset for determinism.
  - In-flight transactions are discarded.
- Operands are sampled only on the accept edge; they may change freely otherwise.

Optional Feature:
- Macro: MODULUS_CSA_ACCUM_FINAL_CPA_EN.
- When defined:
  - Adds stage S4, a carry-propagate add of the S3 pair.
  - out_sum = full binary sum and out_carry = 0.
  - Latency becomes 4 and buffering capacity becomes 4; handshake rules are unchanged.
- When undefined: 3-stage redundant output as above.

Decomposition:
- Package modulus_accum_pkg holds:
  - Constants: default MODULUS_WIDTH, NUM_TERMS, GUARD_BITS.
  - Function num_csa_levels(n).
  - Typedef for an OUT_WIDTH operand vector.
- One sub-module, csa_3to2: purely combinational and width-parameterized. Outputs are sum = a^b^c and carry = maj(a,b,c) << 1, truncated to width.
- The stage/valid logic stays in the top module.

Test Plan:
1. Reset, then in_valid=1 with low_part=5 and moduli_terms[i]=i+1 (sum 60), out_ready=1 -> out_valid rises exactly 3 cycles after accept, out_sum+out_carry=60.
2. All 11 operands = 2^1024-1 -> (out_sum+out_carry) mod 2^1028 = 11*(2^1024-1), with no overflow loss.
3. Back-to-back stream of 20 random transactions, out_ready=1 -> in_ready stays 1 and 20 results arrive in order on consecutive cycles, each matching a reference model.
4. out_ready=0 while pushing 5 transactions -> in_ready=0 after the 3rd accept, held outputs are stable. Raise out_ready -> the 3 results drain in order with none lost.
5. Assert rst_n=0 with 2 transactions in flight -> out_valid=0 immediately (asynchronous), and no stale result appears after release.
6. With MODULUS_CSA_ACCUM_FINAL_CPA_EN defined, repeat scenario 1 -> latency 4, out_sum=60, out_carry=0.
